// File: rtl/mini_lab0_pkg.sv
// Shared types and defaults for the switch-to-LED mirror sequencer.
package mini_lab0_pkg;

   localparam int              WIDTH_DEF        = 10;
   localparam int              POLL_CYCLES_DEF  = 2;
   localparam logic [9:0]      HALT_PATTERN_DEF = 10'h3FF;

   // Sequencer states; the fourth encoding is illegal and recovers to POLL.
   typedef enum logic [1:0] {
      POLL   = 2'd0,
      UPDATE = 2'd1,
      HALT   = 2'd2
   } state_t;

   // Bits needed for a counter that spans 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mini_lab0_if.sv
// Switch/LED bus between the board pins and the sequencer.
interface mini_lab0_if
   import mini_lab0_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] ledr;

   // Board side drives the switches and watches the LEDs.
   modport master (output sw, input ledr);
   // Sequencer side reads the switches and owns the LED register.
   modport slave  (input sw, output ledr);
endinterface

// File: rtl/mini_lab0_ctrl.sv
// Polling sequencer: waits POLL_CYCLES, then spends one UPDATE cycle
// copying the switches onto the LEDs, or halts on the halt pattern.
module mini_lab0_ctrl
   import mini_lab0_pkg::*;
#(
   parameter int               WIDTH        = WIDTH_DEF,
   parameter int               POLL_CYCLES  = POLL_CYCLES_DEF,
   parameter logic [WIDTH-1:0] HALT_PATTERN = HALT_PATTERN_DEF
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   mini_lab0_if.slave  bus
);

   localparam int            CW       = cnt_width(POLL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(POLL_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_ledr;
   logic [WIDTH-1:0] w_ledr_nxt;
   logic             hlt;
   logic             w_hlt_nxt;
   logic             update_LED;

   // State, poll counter, LED register and halt flag; reset is immediate.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= POLL;
         r_cnt   <= '0;
         r_ledr  <= '0;
         hlt     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ledr  <= w_ledr_nxt;
         hlt     <= w_hlt_nxt;
      end
   end

   // Next-state and output decode. SW is sampled at the edge that closes
   // UPDATE, so a switch change made mid-UPDATE still lands on the LEDs.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ledr_nxt  = r_ledr;
      w_hlt_nxt   = hlt;
      update_LED  = 1'b0;
      case (r_state)
         POLL: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = UPDATE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         UPDATE: begin
            update_LED = 1'b1;
            w_cnt_nxt  = '0;
            if (bus.sw == HALT_PATTERN) begin
               // LEDs keep the last mirrored value once halted.
               w_state_nxt = HALT;
               w_hlt_nxt   = 1'b1;
            end else begin
               w_ledr_nxt  = bus.sw;
               w_state_nxt = POLL;
            end
         end
         HALT: begin
            // Absorbing: only reset leaves, switches are ignored.
            w_cnt_nxt = '0;
            w_hlt_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = POLL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign bus.ledr = r_ledr;

endmodule

// File: rtl/mini_lab0.sv
// Board-level top: pins in, LEDs out; KEY0 is the active-low reset.
module mini_lab0
   import mini_lab0_pkg::*;
#(
   parameter int               WIDTH        = WIDTH_DEF,
   parameter int               POLL_CYCLES  = POLL_CYCLES_DEF,
   parameter logic [WIDTH-1:0] HALT_PATTERN = HALT_PATTERN_DEF
)(
   input  logic             clk,
   input  logic             KEY0,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] LEDR
);

   logic w_rst_n;

   // Push-button reads 0 when pressed, which is the reset level we want.
   assign w_rst_n = KEY0;

   mini_lab0_if #(.WIDTH(WIDTH)) w_bus ();

   // Switches go straight in with no synchronizer: they are quasi-static.
   assign w_bus.sw = SW;
   assign LEDR     = w_bus.ledr;

   mini_lab0_ctrl #(
      .WIDTH        (WIDTH),
      .POLL_CYCLES  (POLL_CYCLES),
      .HALT_PATTERN (HALT_PATTERN)
   ) icpu (
      .i_clk   (clk),
      .i_rst_n (w_rst_n),
      .bus     (w_bus)
   );

endmodule

// File: tb/tb_mini_lab0.sv
// Directed bench for mini_lab0: table of mirror vectors plus hand-written
// sequences for reset timing, update period, halt and mid-UPDATE capture.
module tb_mini_lab0;
   import mini_lab0_pkg::*;

   localparam int W  = 10;
   localparam int PC = 2;

   logic clk = 1'b0;
   logic KEY0;

   mini_lab0_if #(.WIDTH(W)) bus ();

   mini_lab0 #(
      .WIDTH        (W),
      .POLL_CYCLES  (PC),
      .HALT_PATTERN (10'h3FF)
   ) dut (
      .clk  (clk),
      .KEY0 (KEY0),
      .SW   (bus.sw),
      .LEDR (bus.ledr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] sw;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance negedge by negedge until update_LED is seen high (bounded).
   task automatic wait_pulse(input int maxc, output int cycles, output bit ok);
      ok     = 1'b0;
      cycles = 0;
      while (cycles < maxc && !ok) begin
         @(negedge clk);
         cycles++;
         if (dut.icpu.update_LED === 1'b1) ok = 1'b1;
      end
   endtask

   // Drive SW, wait for the UPDATE cycle, check LEDR right after it closes.
   task automatic mirror(input string name, input logic [W-1:0] v, input logic [W-1:0] exp);
      int c;
      bit ok;
      @(negedge clk);
      bus.sw = v;
      wait_pulse(20, c, ok);
      chk({name, "_pulse_seen"}, 32'(ok), 32'd1);
      @(negedge clk);
      chk({name, "_upd_low"}, 32'(dut.icpu.update_LED), 32'd0);
      chk(name, 32'(bus.ledr), 32'(exp));
   endtask

   initial begin
      int  c;
      bit  ok;
      int  pulses;
      logic [W-1:0] rv;

      vecs[0]  = '{sw: 10'h155, exp: 10'h155};
      vecs[1]  = '{sw: 10'h2AA, exp: 10'h2AA};
      vecs[2]  = '{sw: 10'h000, exp: 10'h000};
      vecs[3]  = '{sw: 10'h3FE, exp: 10'h3FE};
      vecs[4]  = '{sw: 10'h1FF, exp: 10'h1FF};
      vecs[5]  = '{sw: 10'h200, exp: 10'h200};
      vecs[6]  = '{sw: 10'h001, exp: 10'h001};
      vecs[7]  = '{sw: 10'h37F, exp: 10'h37F};
      vecs[8]  = '{sw: 10'h0F0, exp: 10'h0F0};
      vecs[9]  = '{sw: 10'h3BF, exp: 10'h3BF};
      vecs[10] = '{sw: 10'h2FF, exp: 10'h2FF};
      vecs[11] = '{sw: 10'h123, exp: 10'h123};

      // Reset held: switches must not reach the LEDs.
      KEY0   = 1'b0;
      bus.sw = 10'h155;
      repeat (4) @(negedge clk);
      chk("rst_ledr", 32'(bus.ledr), 32'd0);
      chk("rst_hlt", 32'(dut.icpu.hlt), 32'd0);
      chk("rst_upd", 32'(dut.icpu.update_LED), 32'd0);

      // First pulse comes exactly POLL_CYCLES edges after release.
      KEY0 = 1'b1;
      wait_pulse(20, c, ok);
      chk("first_pulse_seen", 32'(ok), 32'd1);
      chk("first_pulse_lat", 32'(c), 32'(PC));

      // Period between successive UPDATE cycles is POLL_CYCLES+1.
      wait_pulse(20, c, ok);
      chk("period_seen", 32'(ok), 32'd1);
      chk("period", 32'(c), 32'(PC + 1));

      // Table of directed mirror vectors.
      for (int i = 0; i < 12; i++)
         mirror($sformatf("vec%0d", i), vecs[i].sw, vecs[i].exp);

      // Random non-halt values, applied on a negedge.
      for (int i = 0; i < 30; i++) begin
         rv = W'($urandom_range(0, 1022));
         mirror($sformatf("rnd%0d", i), rv, rv);
      end

      // LEDR must not follow SW while polling.
      mirror("pre_poll", 10'h0F0, 10'h0F0);
      bus.sw = 10'h10F;
      @(negedge clk);
      chk("poll_hold", 32'(bus.ledr), 32'h0F0);
      wait_pulse(20, c, ok);
      @(negedge clk);
      chk("poll_follow", 32'(bus.ledr), 32'h10F);

      // SW changed in the middle of UPDATE is captured at its closing edge.
      @(negedge clk);
      bus.sw = 10'h123;
      wait_pulse(20, c, ok);
      chk("midupd_seen", 32'(ok), 32'd1);
      bus.sw = 10'h321;
      @(negedge clk);
      chk("midupd_capture", 32'(bus.ledr), 32'h321);

      // Halt: flag rises within POLL_CYCLES+1, LEDR frozen, no more pulses.
      mirror("pre_halt", 10'h0AB, 10'h0AB);
      @(negedge clk);
      bus.sw = 10'h3FF;
      c = 0;
      while (c < 20 && dut.icpu.hlt !== 1'b1) begin
         @(negedge clk);
         c++;
      end
      chk("hlt_rise", 32'(dut.icpu.hlt), 32'd1);
      chk("hlt_latency_ok", 32'(c <= PC + 1), 32'd1);
      chk("halt_ledr_hold", 32'(bus.ledr), 32'h0AB);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (dut.icpu.update_LED === 1'b1) pulses++;
      end
      chk("halt_no_pulses", 32'(pulses), 32'd0);
      bus.sw = 10'h001;
      repeat (6) @(negedge clk);
      chk("halt_sw_ignored", 32'(bus.ledr), 32'h0AB);
      chk("halt_stays", 32'(dut.icpu.hlt), 32'd1);

      // Async reset from HALT, asserted between clock edges.
      @(posedge clk);
      #2 KEY0 = 1'b0;
      #1;
      chk("async_hlt", 32'(dut.icpu.hlt), 32'd0);
      chk("async_ledr", 32'(bus.ledr), 32'd0);
      chk("async_upd", 32'(dut.icpu.update_LED), 32'd0);
      @(negedge clk);
      KEY0 = 1'b1;
      mirror("post_rst", 10'h00F, 10'h00F);
      chk("post_rst_hlt", 32'(dut.icpu.hlt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
